// File: rtl/image_pkg.sv
// Shared types and constants for the image sender.
package image_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FETCH,
    CAPT,
    XMIT,
    CSUM,
    DONE
  } state_t;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         PIX_W          = 8;
  localparam int         NUM_PIXELS_DEF = 76800;
  localparam int         ADDR_W_DEF     = 17;

endpackage

// File: rtl/image_sender.sv
// Streams one frame from external memory: sync header, pixel bytes, optional checksum.
// Define IMAGE_SENDER_CHECKSUM_EN to append the modulo-256 pixel sum after the last pixel.
module image_sender
  import image_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              send,
  output logic              done_send,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  state_t            state;
  logic [ADDR_W-1:0] index;
`ifdef IMAGE_SENDER_CHECKSUM_EN
  logic [PIX_W-1:0]  checksum;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      done_send <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      index     <= '0;
`ifdef IMAGE_SENDER_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (send) begin
            state    <= HDR;
            tx_valid <= 1'b1;
            tx_data  <= SYNC_BYTE;
`ifdef IMAGE_SENDER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        HDR: begin
          if (tx_ready) begin
            state     <= FETCH;
            tx_valid  <= 1'b0;
            index     <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
          end
        end
        FETCH: begin
          mem_rd_en <= 1'b0;
          state     <= CAPT;
        end
        // Memory data is valid in this cycle, one cycle after the read strobe.
        CAPT: begin
          tx_data  <= mem_rdata;
          tx_valid <= 1'b1;
`ifdef IMAGE_SENDER_CHECKSUM_EN
          checksum <= checksum + mem_rdata;
`endif
          state    <= XMIT;
        end
        XMIT: begin
          if (tx_ready) begin
            index <= index + 1'b1;
            if (index == LAST_IDX) begin
`ifdef IMAGE_SENDER_CHECKSUM_EN
              state    <= CSUM;
              tx_data  <= checksum;
`else
              state     <= DONE;
              tx_valid  <= 1'b0;
              done_send <= 1'b1;
`endif
            end else begin
              state     <= FETCH;
              tx_valid  <= 1'b0;
              mem_rd_en <= 1'b1;
              mem_addr  <= index + 1'b1;
            end
          end
        end
`ifdef IMAGE_SENDER_CHECKSUM_EN
        CSUM: begin
          if (tx_ready) begin
            state     <= DONE;
            tx_valid  <= 1'b0;
            done_send <= 1'b1;
          end
        end
`endif
        DONE: begin
          done_send <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
